dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL use parameter ADDR_W, default 32, meaning width of the byte address on both the pipeline side and the memory side.
REQ-002 SHALL have ports `clk` (in, 1, the single clock), then `rst_n` (in, 1). Reset is synchronous and active-low.
REQ-003 SHALL have `req_valid` (in, 1): the pipeline presents a MEM-stage request.
REQ-004 SHALL have `memread` and `memwrite` (in, 1 each): access type from the control unit.
REQ-005 SHALL have `memsizesel` (in, 2): 00 word, 01 byte, 10 half; 11 is illegal.
REQ-006 SHALL have `ld_unsigned` (in, 1): funct3[2]; 1 means zero-extend the load result.
REQ-007 SHALL have `addr` (in, ADDR_W) and `wdata` (in, 32): byte address and store data.
REQ-008 SHALL have `stall` (out, 1), `done` (out, 1), `rdata` (out, 32) and `err` (out, 1).
REQ-009 SHALL have a byte-wide synchronous SRAM port: `mem_addr` (out, ADDR_W), `mem_we` (out, 1), `mem_wdata` (out, 8), `mem_rdata` (in, 8). Read data is valid on the cycle after `mem_addr` is presented.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT and DONE.
REQ-011 IDLE SHALL accept a request when `req_valid`=1 and exactly one of `memread`/`memwrite`=1.
- On accept: latch addr, wdata, size, type and sign mode.
- Set beat count n to 1, 2 or 4 (byte, half, word).
- Go to ACCESS.
REQ-012 ACCESS SHALL issue one beat per cycle for k = 0..n-1, little-endian:
- `mem_addr` = latched addr + k.
- Stores: `mem_we`=1 and `mem_wdata` = wdata[8k+7:8k].
- Loads: `mem_we`=0.
REQ-013 For loads, the FSM SHALL capture `mem_rdata` into byte k-1 of an internal buffer on each ACCESS cycle with k≥1. After beat n-1 it goes to WAIT, which captures byte n-1 and goes to DONE.
REQ-014 For stores, the FSM SHALL go from ACCESS directly to DONE after beat n-1.
REQ-015 DONE SHALL last exactly one cycle with `done`=1, then return to IDLE. No new request is accepted in DONE.
REQ-016 In DONE for loads, `rdata` SHALL be the assembled value:
- Byte: sign- or zero-extended from bit 7.
- Half: sign- or zero-extended from bit 15.
- Word: unmodified.
REQ-017 In DONE for stores, `rdata` SHALL be 0. `rdata` SHALL hold its last value outside DONE.
REQ-018 `stall` SHALL be combinational, equal to `req_valid` AND (state != DONE) AND (request legal, or state != IDLE).
REQ-019 Latency from the accept cycle (cycle 0) to `done`:
- Byte load: cycle 3. Half load: cycle 4. Word load: cycle 6.
- Byte store: cycle 2. Half store: cycle 3. Word store: cycle 5.
REQ-020 A request SHALL be illegal if any of the following holds; it is then rejected in IDLE with `err`=1 for one cycle, no memory beat, and `stall`=0:
- `memsizesel`=11.
- Half with addr[0]=1.
- Word with addr[1:0]≠00.
- Both `memread` and `memwrite` = 1.
REQ-021 `req_valid`=1 with both `memread`=0 and `memwrite`=0 SHALL be ignored: no stall, no err.
REQ-022 Input changes during ACCESS, WAIT or DONE SHALL have no effect, because all request fields are latched at accept.
REQ-023 The beat address SHALL wrap modulo 2^ADDR_W.
REQ-024 `mem_we` SHALL be 1 only in ACCESS for a store. `mem_addr` and `mem_wdata` SHALL be don't-care whenever no beat is issued.

Reset
REQ-025 When `rst_n`=0 at a clock edge, the block SHALL enter IDLE with outputs reset as follows:
- `done`=0, `err`=0, `rdata`=0, `mem_we`=0.
- Beat counter = 0.
REQ-026 A reset during ACCESS SHALL abort the access at that edge with no further beats. Bytes already written are not rolled back.

Structure
REQ-027 The shared defines file SHALL hold the size encodings (SZ_W=00, SZ_B=01, SZ_H=10) and the FSM state encodings.
REQ-028 The block SHALL be a single module plus one sub-module, `ld_extend`: combinational, inputs buffer/size/unsigned, output the 32-bit extended result.

Verification
REQ-029 Byte load: mem[0x13]=0x80, signed, addr 0x13 -> `done` at cycle 3 with `rdata`=0xFFFFFF80. Repeat unsigned -> 0x00000080.
REQ-030 Word store then load: word store 0xDEADBEEF to 0x100 -> bytes 0x100..0x103 = EF, BE, AD, DE; `done` at cycle 5. Word load of 0x100 -> `rdata`=0xDEADBEEF at cycle 6.
REQ-031 Half load with signed/unsigned extension: mem[0x22]=0x34, mem[0x23]=0x92; signed -> 0xFFFF9234, unsigned -> 0x00009234, both at cycle 4.
REQ-032 Misaligned/illegal requests: word load at 0x102 -> `err` pulse, no `mem_we`, `stall`=0. Both `memread` and `memwrite` high -> `err`. `memsizesel`=11 -> `err`.
REQ-033 Reset mid-store: word store, `rst_n` low at the 2nd ACCESS cycle -> only byte 0 written, IDLE next cycle, `done` never asserted.
REQ-034 Stall and input-latching timing: back-to-back loads with `req_valid` held high -> `stall` high until DONE and low in DONE. The second accept occurs in the IDLE cycle after DONE. Changing `addr` mid-access does not alter beats.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared size/state encodings and helpers for the data-memory controller
package dmem_ctrl_pkg;

    // Access size encodings as driven by memsizesel
    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Index of the final byte beat for a given size (beats run 0..last)
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Size code is illegal or the address is not naturally aligned for it
    function automatic logic size_bad(input logic [1:0] size, input logic [1:0] lsb);
        return (size == SZ_X) ||
               ((size == SZ_H) && lsb[0]) ||
               ((size == SZ_W) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - pipeline request/response and byte-wide SRAM signals of the controller
// master: pipeline + SRAM side (drives request fields and mem_rdata)
// slave : controller side (drives stall/done/rdata/err and mem_addr/mem_we/mem_wdata)
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              memread;
    logic              memwrite;
    logic [1:0]        memsizesel;
    logic              ld_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic              done;
    logic [31:0]       rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output req_valid, memread, memwrite, memsizesel, ld_unsigned, addr, wdata,
        input  stall, done, rdata, err,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, memread, memwrite, memsizesel, ld_unsigned, addr, wdata,
        output stall, done, rdata, err,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_ctrl_ld_extend.sv
// rtl/dmem_ctrl_ld_extend.sv - sign/zero extension of an assembled load value
// buffer      : assembled little-endian load bytes
// size        : access size code (SZ_B/SZ_H/SZ_W)
// ld_unsigned : 1 = zero-extend, 0 = sign-extend
// ext         : 32-bit extended result
module ld_extend
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] buffer,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] ext
);

    always_comb begin
        ext = buffer;
        case (size)
            SZ_B:    ext = {{24{~ld_unsigned & buffer[7]}}, buffer[7:0]};
            SZ_H:    ext = {{16{~ld_unsigned & buffer[15]}}, buffer[15:0]};
            default: ext = buffer;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage load/store controller serialising accesses onto a byte-wide SRAM
// clk   : single clock
// rst_n : synchronous active-low reset
// bus   : slave side of dmem_ctrl_if (pipeline request/response + SRAM port)
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              is_store_q;
    logic              unsigned_q;
    logic [1:0]        last_q;
    logic [1:0]        beat;
    logic [1:0]        prev_beat;
    logic [31:0]       rbuf;
    logic [31:0]       rdata_q;
    logic [31:0]       ext;
    logic [31:0]       rdata_fin;

    logic              req_typed;
    logic              req_one;
    logic              req_ok;
    logic              req_bad;

    // A request with neither read nor write is ignored entirely; with both it is illegal.
    assign req_typed = bus.memread | bus.memwrite;
    assign req_one   = bus.memread ^ bus.memwrite;
    assign req_bad   = bus.req_valid & req_typed &
                       (~req_one | size_bad(bus.memsizesel, bus.addr[1:0]));
    assign req_ok    = bus.req_valid & req_one &
                       ~size_bad(bus.memsizesel, bus.addr[1:0]);

    assign prev_beat = beat - 2'd1;

    // Beat address wraps naturally at ADDR_W bits
    assign bus.mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, beat};
    assign bus.mem_wdata = wdata_q[{beat, 3'b000} +: 8];

    ld_extend u_ld_extend (
        .buffer      (rbuf),
        .size        (size_q),
        .ld_unsigned (unsigned_q),
        .ext         (ext)
    );

    assign rdata_fin = is_store_q ? 32'd0 : ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.stall  = 1'b0;
        bus.done   = 1'b0;
        bus.err    = 1'b0;
        bus.mem_we = 1'b0;
        bus.rdata  = rdata_q;
        case (state)
            ST_IDLE: begin
                bus.err   = req_bad;
                bus.stall = req_ok;
                if (req_ok) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.stall  = bus.req_valid;
                // Gated by rst_n so a reset landing mid-store drops the beat on that same edge
                bus.mem_we = is_store_q & rst_n;
                if (beat == last_q) begin
                    state_next = is_store_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus.stall  = bus.req_valid;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                bus.done   = 1'b1;
                bus.rdata  = rdata_fin;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            size_q     <= SZ_W;
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            last_q     <= 2'd0;
            beat       <= 2'd0;
            rbuf       <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        addr_q     <= bus.addr;
                        wdata_q    <= bus.wdata;
                        size_q     <= bus.memsizesel;
                        is_store_q <= bus.memwrite;
                        unsigned_q <= bus.ld_unsigned;
                        last_q     <= last_beat(bus.memsizesel);
                        beat       <= 2'd0;
                        rbuf       <= 32'd0;
                    end
                end
                ST_ACCESS: begin
                    // SRAM returns data one cycle late, so beat k carries byte k-1
                    if (!is_store_q && (beat != 2'd0)) begin
                        rbuf[{prev_beat, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    // Counter parks on the last beat so WAIT knows which byte lands
                    if (beat != last_q) begin
                        beat <= beat + 2'd1;
                    end
                end
                ST_WAIT: begin
                    rbuf[{beat, 3'b000} +: 8] <= bus.mem_rdata;
                end
                ST_DONE: begin
                    rdata_q <= rdata_fin;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
